// File: rtl/xor5_parity_frame_checker.sv
// Frame-level parity checker around a 5-input XOR.
// Accumulates word parity per frame, checks against a trailing word.
module xor5_parity_frame_checker #(
  parameter int FRAME_LEN = 8,
  parameter int ERR_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_data,
  input  logic             frame_abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_ok,
  output logic             out_parity,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int CW = $clog2(FRAME_LEN);

  typedef enum logic [1:0] {
    COLLECT,
    CHECK,
    REPORT
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            acc;
  logic [CW-1:0]   cnt;
  logic            p;
  logic            in_hs;
  logic            out_hs;
  logic            last;
  logic            fail;

  assign p      = ^in_data;
  assign in_hs  = in_valid & in_ready;
  assign out_hs = out_valid & out_ready;
  assign last   = (cnt == CW'(FRAME_LEN - 1));
  assign fail   = (acc != in_data[0]);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= COLLECT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and handshake readiness; abort overrides everything
  always_comb begin
    state_nxt = state;
    in_ready  = (state != REPORT);
    if (frame_abort) begin
      state_nxt = COLLECT;
    end else begin
      unique case (state)
        COLLECT: if (in_hs && last) state_nxt = CHECK;
        CHECK:   if (in_hs)         state_nxt = REPORT;
        REPORT:  if (out_hs)        state_nxt = COLLECT;
        default:                    state_nxt = COLLECT;
      endcase
    end
  end

  // Parity accumulator, word counter, result and error counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= 1'b0;
      cnt        <= '0;
      out_valid  <= 1'b0;
      out_ok     <= 1'b0;
      out_parity <= 1'b0;
      err_cnt    <= '0;
    end else if (frame_abort) begin
      acc       <= 1'b0;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        COLLECT: begin
          if (in_hs) begin
            acc <= acc ^ p;
            cnt <= last ? '0 : cnt + 1'b1;
          end
        end
        CHECK: begin
          if (in_hs) begin
            out_parity <= acc;
            out_ok     <= ~fail;
            out_valid  <= 1'b1;
            if (fail && (err_cnt != '1)) begin
              err_cnt <= err_cnt + 1'b1;
            end
          end
        end
        REPORT: begin
          if (out_hs) begin
            out_valid <= 1'b0;
            acc       <= 1'b0;
          end
        end
        default: begin
          acc <= 1'b0;
          cnt <= '0;
        end
      endcase
    end
  end

endmodule
